// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus: program-memory request/ack, branch redirect and the instruction
// handshake toward the core. The fetch queue is the master side.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_data;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    input  branch_valid, branch_target,
    output inst, inst_pc, inst_valid,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    output branch_valid, branch_target,
    input  inst, inst_pc, inst_valid,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: single-outstanding program-memory fetch feeding a small
// prefetch FIFO of {word, pc}; a branch redirect flushes the FIFO and any in-flight fetch.
//
// state    | meaning
// ST_IDLE  | no fetch outstanding; may issue a request
// ST_WAIT  | request outstanding, its data will be queued
// ST_DRAIN | request outstanding but cancelled by a branch; data is dropped
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  inst_fetch_queue_if.master     bus,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, pc_nxt;
  logic              req_nxt;
  logic              push;
  logic              pop;
  logic              room_idle;
  logic              room_chain;

  logic [INST_W-1:0] word_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  assign pop        = (count != '0) && bus.inst_ready;
  assign room_idle  = (count < FULL_CNT) || pop;
  // An ack that also re-requests must leave a slot for the next ack after its own push.
  assign room_chain = (count < LAST_CNT) || pop;

  // An ack with room issues the next fetch at once, passing through IDLE in the same
  // cycle, so a 1-cycle memory sustains one instruction every two cycles.
  always_comb begin
    state_nxt = state;
    pc_nxt    = fetch_pc;
    req_nxt   = 1'b0;
    push      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!bus.branch_valid && enable && room_idle) begin
          req_nxt   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.branch_valid) begin
          state_nxt = bus.imem_ack ? ST_IDLE : ST_DRAIN;
        end else if (bus.imem_ack) begin
          push   = 1'b1;
          pc_nxt = fetch_pc + 1'b1;
          if (enable && room_chain) begin
            req_nxt = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.imem_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (bus.branch_valid) begin
      pc_nxt = bus.branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      fetch_pc      <= '0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= pc_nxt;
      bus.imem_req <= req_nxt;
      if (req_nxt) begin
        bus.imem_addr <= pc_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.branch_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= bus.imem_data;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  assign bus.inst_valid = (count != '0);
  assign bus.inst       = bus.inst_valid ? word_mem[rd_ptr] : '0;
  assign bus.inst_pc    = bus.inst_valid ? pc_mem[rd_ptr] : '0;
  assign occupancy      = count;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: cycle table for reset/cold start/fill, then
// hand-written sequences for streaming, branch redirects, PC wrap and enable gating.
module tb_inst_fetch_queue;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [2:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cnt      = 0;
  logic [7:0] pend;
  logic       prev_req = 1'b0;

  inst_fetch_queue_if #(.ADDR_W(8), .INST_W(16)) bus ();

  inst_fetch_queue #(.DEPTH(4), .ADDR_W(8), .INST_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program memory: one outstanding read, word = 16'h0400 + addr, ack 'lat' cycles after req.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt           = 0;
      bus.imem_ack  = 1'b0;
      bus.imem_data = 16'h0000;
    end else begin
      bus.imem_ack = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = 16'h0400 + 16'(pend);
        end
      end
      if (bus.imem_req) begin
        cnt  = lat;
        pend = bus.imem_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("req_not_back_to_back", {31'd0, bus.imem_req & prev_req}, 32'd0);
    end
    prev_req = bus.imem_req;
  end

  typedef struct {
    logic       rst_n;
    logic       enable;
    logic       ready;
    logic       exp_req;
    logic [7:0] exp_addr;
    logic       exp_valid;
    logic [15:0] exp_inst;
    logic [7:0] exp_pc;
    logic [2:0] exp_occ;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    logic [7:0] exp_pc;
    logic       saw0, saw1, found, req_seen;
    int         pops;

    bus.inst_ready    = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 8'h00;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 3'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 3'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 3'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 16'h0400, 8'h00, 3'd1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0400, 8'h00, 3'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 16'h0400, 8'h00, 3'd2};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0400, 8'h00, 3'd2};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 16'h0400, 8'h00, 3'd3};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0400, 8'h00, 3'd3};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0400, 8'h00, 3'd4};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0400, 8'h00, 3'd4};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 16'h0401, 8'h01, 3'd3};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0401, 8'h01, 3'd3};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0401, 8'h01, 3'd4};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0401, 8'h01, 3'd4};

    // Reset, cold start with 1-cycle memory, fill to full, single pop.
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      rst_n          = vecs[i].rst_n;
      enable         = vecs[i].enable;
      bus.inst_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("v%0d_req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req || !vecs[i].rst_n)
        check($sformatf("v%0d_addr", i), {24'd0, bus.imem_addr}, {24'd0, vecs[i].exp_addr});
      check($sformatf("v%0d_valid", i), {31'd0, bus.inst_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_inst", i), {16'd0, bus.inst}, {16'd0, vecs[i].exp_inst});
      check($sformatf("v%0d_pc", i), {24'd0, bus.inst_pc}, {24'd0, vecs[i].exp_pc});
      check($sformatf("v%0d_occ", i), {29'd0, occupancy}, {29'd0, vecs[i].exp_occ});
    end

    // Continuous consumption: in-order stream, occupancy settles to 0/1, one word per 2 cycles.
    bus.inst_ready = 1'b1;
    exp_pc = 8'h01;
    saw0 = 1'b0;
    saw1 = 1'b0;
    pops = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.inst_valid) begin
        check("stream_pc", {24'd0, bus.inst_pc}, {24'd0, exp_pc});
        check("stream_inst", {16'd0, bus.inst}, {16'd0, 16'h0400 + 16'(exp_pc)});
        exp_pc++;
        if (k >= 20) pops++;
      end
      if (k >= 12) begin
        check("stream_occ_le1", {31'd0, occupancy <= 3'd1}, 32'd1);
        if (occupancy == 3'd0) saw0 = 1'b1;
        if (occupancy == 3'd1) saw1 = 1'b1;
      end
      @(negedge clk);
    end
    check("stream_toggle", {30'd0, saw0, saw1}, 32'd3);
    check("stream_rate", pops, 10);

    // Branch one cycle after the request to 8'h05, 3-cycle memory.
    lat = 3;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h05;
    @(negedge clk);
    bus.branch_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.imem_req && bus.imem_addr == 8'h05) found = 1'b1;
      else @(negedge clk);
    end
    check("b_req05_seen", {31'd0, found}, 32'd1);
    @(negedge clk);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h40;
    @(negedge clk);
    bus.branch_valid = 1'b0;
    check("b_flush_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("b_flush_occ", {29'd0, occupancy}, 32'd0);
    check("b_no_req", {31'd0, bus.imem_req}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("b_drain_no_req", {31'd0, bus.imem_req}, 32'd0);
      check("b_drain_valid", {31'd0, bus.inst_valid}, 32'd0);
    end
    @(negedge clk);
    check("b_req_target", {31'd0, bus.imem_req}, 32'd1);
    check("b_addr_target", {24'd0, bus.imem_addr}, 32'h40);
    repeat (4) @(negedge clk);
    check("b_head_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("b_head_pc", {24'd0, bus.inst_pc}, 32'h40);
    check("b_head_inst", {16'd0, bus.inst}, 32'h0440);

    // Branch landing in the same cycle as the ack (and a pop): word dropped, FIFO flushed.
    bus.inst_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.imem_req) found = 1'b1;
      else @(negedge clk);
    end
    check("c_req_seen", {31'd0, found}, 32'd1);
    repeat (3) @(negedge clk);
    check("c_occ_pre", {29'd0, occupancy}, 32'd1);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h80;
    bus.inst_ready    = 1'b1;
    @(negedge clk);
    bus.branch_valid = 1'b0;
    bus.inst_ready   = 1'b0;
    check("c_flush_occ", {29'd0, occupancy}, 32'd0);
    check("c_flush_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("c_no_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    check("c_req_target", {31'd0, bus.imem_req}, 32'd1);
    check("c_addr_target", {24'd0, bus.imem_addr}, 32'h80);
    repeat (4) @(negedge clk);
    check("c_head_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("c_head_pc", {24'd0, bus.inst_pc}, 32'h80);
    check("c_head_inst", {16'd0, bus.inst}, 32'h0480);
    check("c_head_occ", {29'd0, occupancy}, 32'd1);

    // PC wrap FE -> FF -> 00, then enable dropped while the fetch of 00 is outstanding.
    enable = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("d_quiet_occ", {29'd0, occupancy}, 32'd0);
    lat = 1;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'hFE;
    enable = 1'b1;
    @(negedge clk);
    bus.branch_valid = 1'b0;
    check("d_no_req_branch", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    check("d_req_fe", {31'd0, bus.imem_req}, 32'd1);
    check("d_addr_fe", {24'd0, bus.imem_addr}, 32'hFE);
    repeat (2) @(negedge clk);
    check("d_req_ff", {31'd0, bus.imem_req}, 32'd1);
    check("d_addr_ff", {24'd0, bus.imem_addr}, 32'hFF);
    check("d_head_fe", {24'd0, bus.inst_pc}, 32'hFE);
    check("d_inst_fe", {16'd0, bus.inst}, 32'h04FE);
    repeat (2) @(negedge clk);
    check("d_req_00", {31'd0, bus.imem_req}, 32'd1);
    check("d_addr_00", {24'd0, bus.imem_addr}, 32'h00);
    check("d_head_ff", {24'd0, bus.inst_pc}, 32'hFF);
    check("d_inst_ff", {16'd0, bus.inst}, 32'h04FF);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("d_head_00_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("d_head_00", {24'd0, bus.inst_pc}, 32'h00);
    check("d_inst_00", {16'd0, bus.inst}, 32'h0400);
    req_seen = bus.imem_req;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.imem_req) req_seen = 1'b1;
    end
    check("d_gated_no_req", {31'd0, req_seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage feeding the S-Machine CPU core. It walks a fetch PC through program memory with a one-outstanding request/acknowledge protocol and buffers returned 16-bit instruction words in a small prefetch FIFO. It presents them to the core's `inst` input with a valid/ready handshake, and a branch redirect flushes the FIFO and any in-flight fetch.

## Interface
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `ADDR_W`, 8, program address width
- `INST_W`, 16, instruction width
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset: sampled on the rising edge of `clk`, no asynchronous path
- `enable`  in  1  permits new fetch requests; low does not cancel an outstanding fetch or block output
- `imem_req`  out  1  one-cycle request pulse
- `imem_addr`  out  ADDR_W  request address, valid while `imem_req`=1
- `imem_ack`  in  1  read data valid; arrives ≥1 cycle after the request
- `imem_data`  in  INST_W  instruction word, valid with `imem_ack`
- `branch_valid`  in  1  redirect strobe from the core
- `branch_target`  in  ADDR_W  new fetch PC
- `inst`  out  INST_W  head-of-FIFO instruction; 0 when empty
- `inst_pc`  out  ADDR_W  address of `inst`; 0 when empty
- `inst_valid`  out  1  FIFO non-empty
- `inst_ready`  in  1  core consumes head when `inst_valid`&`inst_ready`
- `occupancy`  out  $clog2(DEPTH)+1  entries held

## Operation
- State `fetch_pc` (ADDR_W bits), FIFO of {word, pc}, FSM with IDLE / WAIT / DRAIN.
- IDLE: if `enable`=1, `branch_valid`=0, and `occupancy` < DEPTH, or = DEPTH with a pop this cycle: pulse `imem_req`, drive `imem_addr`=`fetch_pc`, go to WAIT. `imem_ack` in IDLE is ignored.
- WAIT: on `imem_ack`, push {`imem_data`, `fetch_pc`}, set `fetch_pc`+1, go to IDLE. The increment wraps 8'hFF→8'h00.
- DRAIN: wait for `imem_ack`, discard the data, go to IDLE.
- Branch, which overrides everything else in its cycle:
  - clear FIFO, so `occupancy`=0 next cycle;
  - set `fetch_pc`=`branch_target`;
  - no request is issued that cycle;
  - WAIT without ack goes to DRAIN;
  - WAIT with same-cycle ack discards the data and goes to IDLE;
  - DRAIN stays in DRAIN, or goes to IDLE if ack arrives the same cycle.
- Pop: head advances when `inst_valid`&`inst_ready`. Push and pop in the same cycle leave `occupancy` unchanged. A pop coinciding with a branch is absorbed by the flush.
- The FIFO never overflows because a request is issued only when a slot is guaranteed free at ack time.
- Pop when empty is ignored.
- Reset values: `imem_req`=0, `imem_addr`=0, `inst`=0, `inst_pc`=0, `inst_valid`=0, `occupancy`=0, `fetch_pc`=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-fetch drops the outstanding request; its late ack lands in IDLE and is ignored.
- The memory side is reset with the same `rst_n`.

## Timing
- `imem_req` is registered: a decision at edge E makes it high for the single cycle after E, then low. It is never high two consecutive cycles.
- `imem_ack` sampled high at edge A: the entry is visible on `inst`/`inst_valid`/`occupancy` immediately after A.
- With 1-cycle memory (ack one cycle after the req pulse), throughput is 1 instruction per 2 cycles and the first `inst_valid` occurs 2 cycles after the first `imem_req`.
- `inst`, `inst_pc`, `inst_valid` come from registers/FIFO storage, with no combinational path from `inst_ready` or `imem_ack`.
- The branch flush takes effect at the sampling edge: `inst_valid`=0 the following cycle. The first request to `branch_target` leaves IDLE on the next edge, so `imem_req` rises 1 cycle later, or after the DRAIN ack.

## Test plan
- **Reset and cold start:** hold `rst_n`=0 3 cycles, then release with `enable`=1 and 1-cycle memory returning `16'h0400+addr` → requests to 0,1,2,3; `inst` sequence 16'h0400, 16'h0401, … with `inst_pc` 0,1,…; all outputs 0 during reset.
- **Fill/full:** `inst_ready`=0, DEPTH=4 → exactly 4 requests, `occupancy`=4, no further `imem_req`. Assert `inst_ready` for 1 cycle → one pop and one new request to address 4.
- **Simultaneous push/pop:** `inst_ready`=1 continuously → `occupancy` toggles 0/1 and never exceeds 1; no instruction is duplicated or skipped.
- **Branch during WAIT with 3-cycle memory latency:**
  - stimulus: `branch_valid` with target 8'h40 one cycle after the req to 8'h05;
  - FSM goes to DRAIN and the ack data for 8'h05 never appears on `inst`;
  - next request is to 8'h40;
  - FIFO is flushed.
- **Branch coincident with ack:** FIFO is flushed, the acked word is discarded, and `fetch_pc`=target.
- **Wrap and enable gating:** start at `branch_target`=8'hFE → addresses FE, FF, 00. Deassert `enable` while in WAIT → the pending fetch completes and no new `imem_req` follows.
